// File: rtl/io_bus_initiator_if.sv
// Request/response handshake and ABUS/WE bus signals of the I/O bus initiator.
// DBUS is bidirectional and is carried as a separate inout port on the initiator.
interface io_bus_initiator_if #(
  parameter int unsigned BITS = 32
);
  logic            REQ_VALID;
  logic            REQ_READY;
  logic            REQ_WE;
  logic [BITS-1:0] REQ_ADDR;
  logic [BITS-1:0] REQ_WDATA;
  logic            RSP_VALID;
  logic            RSP_READY;
  logic [BITS-1:0] RSP_RDATA;
  logic            RSP_ERR;
  logic [BITS-1:0] ABUS;
  logic            WE;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ABUS, WE
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ABUS, WE
  );
endinterface

// File: rtl/io_bus_initiator.sv
// Single-outstanding load/store initiator for the shared ABUS/DBUS/WE I/O bus.
// Define BUSINIT_POSTED_WRITE_EN to post writes (writes return no response).
module io_bus_initiator #(
  parameter int unsigned     BITS        = 32,
  parameter int unsigned     WAIT_CYCLES = 1,
  parameter logic [BITS-1:0] IDLE_ADDR   = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOCK,
  inout  wire  [BITS-1:0]   DBUS,
  io_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef BUSINIT_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      wait_q, wait_d;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic req_ready;
  logic req_fire;
  logic on_bus;
  logic last_access;

  assign req_ready   = (state_q == S_IDLE) && LOCK && RST;
  assign req_fire    = bus.REQ_VALID && req_ready;
  assign on_bus      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign last_access = (state_q == S_ACCESS) && (wait_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          we_d    = bus.REQ_WE;
          rdata_d = '0;
          if (bus.REQ_ADDR[1:0] != '0) begin
            // A posted misaligned write is dropped: stay idle, report nothing.
            err_d   = !(POSTED && bus.REQ_WE);
            state_d = (POSTED && bus.REQ_WE) ? S_IDLE : S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        wait_d = WAIT_INIT;
        if (!LOCK) begin
          err_d   = !(POSTED && we_q);
          rdata_d = '0;
          state_d = (POSTED && we_q) ? S_IDLE : S_RESP;
        end else begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (!LOCK) begin
          err_d   = !(POSTED && we_q);
          rdata_d = '0;
          state_d = (POSTED && we_q) ? S_IDLE : S_RESP;
        end else if (wait_q != '0) begin
          wait_d = wait_q - 4'd1;
        end else if (we_q) begin
          state_d = POSTED ? S_IDLE : S_RESP;
        end else begin
          rdata_d = DBUS;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.RSP_READY) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = (state_q == S_RESP);
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;
  assign bus.ABUS      = on_bus ? addr_q : IDLE_ADDR;
  // LOCK gates the strobe so a drop in the final ACCESS cycle never writes.
  assign bus.WE        = last_access && we_q && LOCK && RST;
  assign DBUS          = (on_bus && we_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Bench for io_bus_initiator: directed vector table, reset/LOCK sequences and
// randomized transactions against a register-file responder and reference model.
module tb_io_bus_initiator;
  localparam int unsigned W      = 1;
  localparam logic [31:0] IDLE_A = 32'h0000_0000;
  localparam logic [31:0] PARK   = 32'h3C3C_C3C3;
`ifdef BUSINIT_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  wire  [31:0] DBUS;
  logic        tb_drv;
  logic [31:0] tb_dat;
  logic        cur_we;

  assign DBUS = tb_drv ? tb_dat : 'z;

  io_bus_initiator_if #(.BITS(32)) bif ();

  io_bus_initiator #(
    .BITS(32),
    .WAIT_CYCLES(W),
    .IDLE_ADDR(IDLE_A)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .LOCK(lock),
    .DBUS(DBUS),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pmem [logic [31:0]];  // responder registers
  logic [31:0] mmem [logic [31:0]];  // model's view of the same registers

  typedef struct {
    bit          rsp;
    bit          err;
    logic [31:0] rdata;
    int          bus_end;
    int          we_cyc;
  } pred_t;

  typedef struct {
    bit          done;
    bit          got_rsp;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          we_cnt;
    int          we_cyc;
    int          bus_bad;
    int          hold_bad;
    int          rr_bad;
    int          after_bad;
  } obs_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          drop;
    int          hold;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_wecyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pinit(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] prd(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : pinit(a);
  endfunction

  // Reference: outcome of one request from the bus rules, W and the LOCK-drop cycle.
  function automatic pred_t model(input bit we, input logic [31:0] a, input logic [31:0] d,
                                  input int drop);
    pred_t p;
    bit mis   = (a % 4) != 0;
    bit abort = !mis && drop >= 1 && drop <= 2 + int'(W);
    p.err     = mis || abort;
    p.bus_end = mis ? 1 : (abort ? drop + 1 : 3 + int'(W));
    p.rsp     = !(POSTED && we);
    p.we_cyc  = (we && !p.err) ? 2 + int'(W) : 0;
    p.rdata   = (!we && !p.err) ? (mmem.exists(a) ? mmem[a] : pinit(a)) : 32'h0;
    if (we && !p.err) mmem[a] = d;
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
    tb_drv = !(cur_we && bif.ABUS != IDLE_A);
    tb_dat = (bif.ABUS == IDLE_A) ? PARK : prd(bif.ABUS);
  endtask

  task automatic settle();
    #1;
    if (bif.WE) pmem[bif.ABUS] = DBUS;
  endtask

  task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input int drop, input int hold, input int bus_end,
                         input bit exp_rsp, output obs_t o);
    int vcnt;
    int wcnt;
    bit accepted;
    logic [31:0] exp_abus, exp_dbus;
    o.done = 0; o.got_rsp = 0; o.lat = 0; o.err = 0; o.rdata = '0;
    o.we_cnt = 0; o.we_cyc = 0; o.bus_bad = 0; o.hold_bad = 0; o.rr_bad = 0; o.after_bad = 0;
    bif.REQ_VALID = 1'b1; bif.REQ_WE = we; bif.REQ_ADDR = a; bif.REQ_WDATA = d;
    lock = 1'b1;
    bif.RSP_READY = (hold == 0);
    settle();
    wcnt = 0;
    while (!bif.REQ_READY && wcnt < 20) begin
      next_cycle();
      settle();
      wcnt++;
    end
    check("req_ready_idle", 32'(bif.REQ_READY), 32'd1);
    if (!bif.REQ_READY) begin
      bif.REQ_VALID = 1'b0;
      return;
    end
    cur_we = we;
    vcnt = 0;
    accepted = 0;
    for (int k = 1; k <= 60; k++) begin
      next_cycle();
      bif.REQ_VALID = 1'b0;
      bif.REQ_WE    = 1'($urandom);
      bif.REQ_ADDR  = $urandom;
      bif.REQ_WDATA = $urandom;
      lock          = (k != drop);
      bif.RSP_READY = (vcnt >= hold);
      settle();
      if (accepted || (!exp_rsp && k == bus_end)) begin
        if (bif.RSP_VALID !== 1'b0) o.after_bad++;
        if (bif.REQ_READY !== lock) o.after_bad++;
        o.done = 1;
        break;
      end
      exp_abus = (k < bus_end) ? a : IDLE_A;
      exp_dbus = (we && k < bus_end) ? d : tb_dat;
      if (bif.ABUS !== exp_abus) o.bus_bad++;
      if (DBUS !== exp_dbus) o.bus_bad++;
      if (bif.REQ_READY) o.rr_bad++;
      if (bif.WE) begin
        o.we_cnt++;
        o.we_cyc = k;
      end
      if (bif.RSP_VALID) begin
        if (vcnt == 0) begin
          o.got_rsp = 1;
          o.lat     = k;
          o.err     = bif.RSP_ERR;
          o.rdata   = bif.RSP_RDATA;
        end else if (bif.RSP_ERR !== o.err || bif.RSP_RDATA !== o.rdata) begin
          o.hold_bad++;
        end
        vcnt++;
        if (bif.RSP_READY) accepted = 1;
      end
    end
    check("txn_done", 32'(o.done), 32'd1);
    lock = 1'b1;
    bif.RSP_READY = 1'b0;
    cur_we = 1'b0;
  endtask

  task automatic compare(input string tag, input obs_t o, input bit exp_rsp, input bit e_err,
                         input logic [31:0] e_rd, input int e_lat, input int e_wecyc);
    check($sformatf("%s.rsp", tag), 32'(o.got_rsp), 32'(exp_rsp));
    if (exp_rsp) begin
      check($sformatf("%s.lat", tag), 32'(o.lat), 32'(e_lat));
      check($sformatf("%s.err", tag), 32'(o.err), 32'(e_err));
      check($sformatf("%s.rdata", tag), o.rdata, e_rd);
    end
    check($sformatf("%s.we_cnt", tag), 32'(o.we_cnt), 32'(e_wecyc != 0));
    check($sformatf("%s.we_cyc", tag), 32'(o.we_cyc), 32'(e_wecyc));
    check($sformatf("%s.bus", tag), 32'(o.bus_bad), 32'd0);
    check($sformatf("%s.hold", tag), 32'(o.hold_bad), 32'd0);
    check($sformatf("%s.req_ready_busy", tag), 32'(o.rr_bad), 32'd0);
    check($sformatf("%s.after", tag), 32'(o.after_bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [14];
    pred_t p;
    obs_t  o;
    int    seen;
    bit    we;
    logic [31:0] a, d;
    int    drop, hold;

    tbl[0]  = '{1'b1, 32'hFFFF_F104, 32'h0000_000A, 0, 0, 1'b0, 32'h0,         4, 3};
    tbl[1]  = '{1'b0, 32'hFFFF_F104, 32'h0,         0, 0, 1'b0, 32'h0000_000A, 4, 0};
    tbl[2]  = '{1'b1, 32'hFFFF_F108, 32'h0000_0010, 0, 1, 1'b0, 32'h0,         4, 3};
    tbl[3]  = '{1'b0, 32'hFFFF_F108, 32'h0,         0, 0, 1'b0, 32'h0000_0010, 4, 0};
    tbl[4]  = '{1'b0, 32'hFFFF_F102, 32'h0,         0, 0, 1'b1, 32'h0,         1, 0};
    tbl[5]  = '{1'b1, 32'hFFFF_F101, 32'h0000_0077, 0, 2, 1'b1, 32'h0,         1, 0};
    tbl[6]  = '{1'b1, 32'hFFFF_F10C, 32'h0000_0055, 2, 0, 1'b1, 32'h0,         3, 0};
    tbl[7]  = '{1'b0, 32'hFFFF_F10C, 32'h0,         0, 0, 1'b0, 32'h5A5A_F10C, 4, 0};
    tbl[8]  = '{1'b0, 32'hFFFF_F104, 32'h0,         0, 5, 1'b0, 32'h0000_000A, 4, 0};
    tbl[9]  = '{1'b1, 32'hFFFF_F110, 32'h0000_0099, 3, 0, 1'b1, 32'h0,         4, 0};
    tbl[10] = '{1'b0, 32'hFFFF_F104, 32'h0,         1, 0, 1'b1, 32'h0,         2, 0};
    tbl[11] = '{1'b1, 32'hFFFF_F114, 32'h0000_1234, 4, 0, 1'b0, 32'h0,         4, 3};
    tbl[12] = '{1'b0, 32'hFFFF_F114, 32'h0,         0, 0, 1'b0, 32'h0000_1234, 4, 0};
    tbl[13] = '{1'b0, 32'hFFFF_F110, 32'h0,         0, 0, 1'b0, 32'h5A5A_F110, 4, 0};

    rst = 1'b0; lock = 1'b1; cur_we = 1'b0; tb_drv = 1'b1; tb_dat = PARK;
    bif.REQ_VALID = 1'b0; bif.REQ_WE = 1'b0; bif.REQ_ADDR = '0; bif.REQ_WDATA = '0;
    bif.RSP_READY = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    settle();
    check("rst.req_ready", 32'(bif.REQ_READY), 32'd0);
    check("rst.rsp_valid", 32'(bif.RSP_VALID), 32'd0);
    check("rst.rsp_rdata", bif.RSP_RDATA, 32'h0);
    check("rst.rsp_err", 32'(bif.RSP_ERR), 32'd0);
    check("rst.abus", bif.ABUS, IDLE_A);
    check("rst.we", 32'(bif.WE), 32'd0);
    check("rst.dbus_z", DBUS, PARK);
    next_cycle();
    rst = 1'b1;
    settle();
    check("rst.req_ready_after", 32'(bif.REQ_READY), 32'd1);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      p = model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].drop);
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].drop, tbl[i].hold, p.bus_end, p.rsp, o);
      compare($sformatf("vec%0d", i), o, p.rsp, tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_lat,
              tbl[i].e_wecyc);
    end

    // LOCK low in IDLE: no acceptance, no bus cycle
    next_cycle();
    lock = 1'b0;
    bif.REQ_VALID = 1'b1; bif.REQ_WE = 1'b0; bif.REQ_ADDR = 32'hFFFF_F104;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      settle();
      if (bif.REQ_READY || bif.ABUS != IDLE_A) seen++;
    end
    check("lock_low.idle", 32'(seen), 32'd0);
    bif.REQ_VALID = 1'b0;
    next_cycle();
    lock = 1'b1;
    settle();

    // Reset asserted in the SETUP cycle of a read: abort, never respond
    bif.REQ_VALID = 1'b1; bif.REQ_WE = 1'b0; bif.REQ_ADDR = 32'hFFFF_F104;
    bif.RSP_READY = 1'b0;
    settle();
    check("rabort.handshake", 32'(bif.REQ_READY), 32'd1);
    next_cycle();
    bif.REQ_VALID = 1'b0;
    rst = 1'b0;
    settle();
    check("rabort.setup_abus", bif.ABUS, 32'hFFFF_F104);
    next_cycle();
    settle();
    check("rabort.abus", bif.ABUS, IDLE_A);
    check("rabort.dbus_z", DBUS, PARK);
    check("rabort.rsp_valid", 32'(bif.RSP_VALID), 32'd0);
    check("rabort.we", 32'(bif.WE), 32'd0);
    check("rabort.req_ready_in_rst", 32'(bif.REQ_READY), 32'd0);
    next_cycle();
    rst = 1'b1;
    bif.RSP_READY = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (bif.RSP_VALID || bif.ABUS != IDLE_A) seen++;
      next_cycle();
    end
    settle();
    check("rabort.no_rsp", 32'(seen), 32'd0);
    check("rabort.req_ready", 32'(bif.REQ_READY), 32'd1);
    bif.RSP_READY = 1'b0;

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom_range(0, 1));
      a    = 32'hFFFF_F100 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      d    = $urandom;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      hold = int'($urandom_range(0, 3));
      p    = model(we, a, d, drop);
      run_txn(we, a, d, drop, hold, p.bus_end, p.rsp, o);
      compare($sformatf("rnd%0d", i), o, p.rsp, p.err, p.rdata, p.bus_end, p.we_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
